multicycle_control_fsm: RTL

- Moore-style main controller that sequences the multicycle MIPS datapath over several clocks per instruction.
- Drives the datapath control lines: PC write, address select, IR write, ALU source selects, register-file and memory write enables, PC source and ALU operation class.
- Sits beside the datapath. It takes the opcode from the instruction register and the ALU zero flag, and returns a combined PC enable.

---
 rtl/multicycle_control_fsm.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore main controller sequencing the multicycle MIPS datapath.
//
// Ports:
//    clock           system clock, rising-edge state updates
//    resetN          asynchronous active-low reset (forces FETCH)
//    op              opcode field instr[31:26] from the instruction register
//    zero            ALU zero flag, used only for the beq PC enable
//    pcEn            PC enable = PCWrite | (branch & zero)
//    IorD            memory address select (0 = PC, 1 = ALUOut)
//    IRWrite         instruction register load
//    ALUSrcA         ALU A select (0 = PC, 1 = RDA)
//    ALUSrcB         ALU B select (00 RDB, 01 4, 10 SignImm, 11 SignImm<<2)
//    memToReg        write-back data select (0 = ALUOut, 1 = memory data)
//    regDst          destination register select (0 = rt, 1 = rd)
//    regWriteEnable  register file write
//    memWrite        data memory write
//    PCSrc           PC source (00 ALUResult, 01 ALUOut, 10 jump target)
//    aluOp           ALU operation class (00 add, 01 sub, 10 funct)
//    illegalOp       one-cycle pulse in DECODE for an unsupported opcode
//    stateQ          current state, for debug
//
// Optional feature: define PERF_COUNTERS_EN to add cycleCount and instrCount
// (32-bit wrapping counters of clocks and of completed instructions).
module multicycle_control_fsm #(
   parameter logic [3:0] RESET_STATE = 4'd0,
   parameter int         OP_W        = 6
) (
   input  logic            clock,
   input  logic            resetN,
   input  logic [OP_W-1:0] op,
   input  logic            zero,
   output logic            pcEn,
   output logic            IorD,
   output logic            IRWrite,
   output logic            ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic            memToReg,
   output logic            regDst,
   output logic            regWriteEnable,
   output logic            memWrite,
   output logic [1:0]      PCSrc,
   output logic [1:0]      aluOp,
   output logic            illegalOp,
   output logic [3:0]      stateQ
`ifdef PERF_COUNTERS_EN
   ,
   output logic [31:0]     cycleCount,
   output logic [31:0]     instrCount
`endif
);
   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

   state_t state, next;
   logic   pc_write, branch, ir_write, reg_write, mem_write, illegal;

   always_ff @(posedge clock or negedge resetN)
      if (!resetN) state <= state_t'(RESET_STATE);
      else state <= next;

   always_comb begin
      next      = FETCH;
      pc_write  = 1'b0;
      branch    = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      illegal   = 1'b0;
      IorD      = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      memToReg  = 1'b0;
      regDst    = 1'b0;
      PCSrc     = 2'b00;
      aluOp     = 2'b00;
      case (state)
         FETCH: begin
            ir_write = 1'b1;
            ALUSrcB  = 2'b01;
            pc_write = 1'b1;
            next     = DECODE;
         end
         DECODE: begin
            // branch target PC+4+(imm<<2) is precomputed into ALUOut here
            ALUSrcB = 2'b11;
            case (op)
               OP_LW, OP_SW: next = MEMADR;
               OP_RTYPE:     next = RTYPEEX;
               OP_BEQ:       next = BEQEX;
               OP_ADDI:      next = ADDIEX;
               OP_J:         next = JEX;
               default:      illegal = 1'b1;
            endcase
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            next    = (op == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            IorD = 1'b1;
            next = MEMWB;
         end
         MEMWB: begin
            memToReg  = 1'b1;
            reg_write = 1'b1;
         end
         MEMWR: begin
            IorD      = 1'b1;
            mem_write = 1'b1;
         end
         RTYPEEX: begin
            ALUSrcA = 1'b1;
            aluOp   = 2'b10;
            next    = RTYPEWB;
         end
         RTYPEWB: begin
            regDst    = 1'b1;
            reg_write = 1'b1;
         end
         BEQEX: begin
            ALUSrcA = 1'b1;
            aluOp   = 2'b01;
            PCSrc   = 2'b01;
            branch  = 1'b1;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            next    = ADDIWB;
         end
         ADDIWB: reg_write = 1'b1;
         JEX: begin
            PCSrc    = 2'b10;
            pc_write = 1'b1;
         end
         default: next = FETCH;
      endcase
   end

   // state already reads FETCH during reset; the enables are also gated so
   // nothing is written while resetN is held low
   assign pcEn           = resetN & (pc_write | (branch & zero));
   assign IRWrite        = resetN & ir_write;
   assign regWriteEnable = resetN & reg_write;
   assign memWrite       = resetN & mem_write;
   assign illegalOp      = resetN & illegal;
   assign stateQ         = state;

`ifdef PERF_COUNTERS_EN
   always_ff @(posedge clock or negedge resetN)
      if (!resetN) begin
         cycleCount <= 32'd0;
         instrCount <= 32'd0;
      end else begin
         cycleCount <= cycleCount + 32'd1;
         if (state != FETCH && next == FETCH) instrCount <= instrCount + 32'd1;
      end
`endif
endmodule
